final_sum_tree: RTL and testbench
=================================

# final_sum_tree

Parametrised, pipelined saturating adder tree that sums NUM_MAC signed MAC partial results into one FIR output sample. It is the generalised successor of the fixed four-input final-sum stage and sits between the MAC lanes and the FIR output port. It adds a valid/ready handshake with full-pipeline stall, a configurable output shift, and a sticky saturation flag.

## Interface
- NUM_MAC, 4: number of MAC lanes; power of two, 2..16; LOG2N = log2(NUM_MAC)
- IN_W, 16: lane width, signed two's complement
- OUT_W, 16: output width, signed; OUT_W <= IN_W+LOG2N-SHIFT
- SHIFT, 1: arithmetic right shift applied to the full sum before saturation, 0..IN_W
- iClk  in  1  clock
- iRst  in  1  asynchronous reset, active-high
- iValid  in  1  input sample valid (replaces delay-enable AND sample-enable qualification)
- oReady  out  1  block can accept a sample this cycle
- iMac  in  NUM_MAC*IN_W  lane k at [k*IN_W +: IN_W]
- oValid  out  1  oFirOut holds a valid sample
- iReady  in  1  downstream accepts oFirOut this cycle
- oFirOut  out  OUT_W  saturated, shifted sum
- oSat  out  1  sticky: a saturated sample was produced
- iSatClr  in  1  synchronous clear of oSat

## Operation
- Accept: iValid && oReady. Output handshake completes on oValid && iReady.
- Stall: stall = oValid && !iReady; oReady = !stall. On stall every pipeline register (data and valid) holds; no sample is dropped or duplicated.
- Tree: LOG2N registered stages; stage s adds pairs, result width IN_W+s, sign-extended per operand before adding (no overflow inside the tree). Full sum width SW = IN_W+LOG2N.
- Output stage (registered): t = sum >>> SHIFT (arithmetic); if t > 2^(OUT_W-1)-1 -> oFirOut = 2^(OUT_W-1)-1; if t < -2^(OUT_W-1) -> oFirOut = -2^(OUT_W-1); else t[OUT_W-1:0].
- oSat set on the cycle a clamped sample is loaded into the output register. iSatClr clears; simultaneous set and clear -> oSat = 1.
- Bubbles (valid=0) advance when not stalled; their data is don't-care, but oFirOut holds its last valid value while oValid = 0.
- Defaults (4 lanes, 16 bit, SHIFT 1) produce the same numeric results as the four-input stage.

## Timing
- Latency: LOG2N+1 cycles from accepting edge to oValid (3 for defaults), absent stalls.
- Throughput: one sample per cycle when iReady held high.
- oReady is combinational from oValid and iReady only; no path from iValid or iMac.
- Reset (iRst high, any cycle, including mid-stream or during stall): all valids 0, all data registers 0, oFirOut = 0, oValid = 0, oSat = 0; oReady = 1 from the cycle after reset deasserts (combinationally 1 while oValid = 0). In-flight samples are discarded.

## Configuration
- FINAL_SUM_ROUND_EN defined: before the shift, add 2^(SHIFT-1) to the full sum (round half up, computed at SW+1 bits so it cannot wrap); no effect when SHIFT = 0.
- Undefined: plain truncation toward minus infinity via arithmetic shift.

## Test plan
- Defaults, iMac lanes all 0x1000, iValid one cycle, iReady=1 -> oValid pulse 3 cycles later, oFirOut = 0x2000, oSat = 0.
- Lanes all 0x7FFF -> oFirOut = 0x7FFF, oSat = 1; then lanes all 0x8000 -> 0x8000; iSatClr asserted same cycle as a new clamp -> oSat stays 1; iSatClr alone -> 0.
- Lanes {1,0,0,0} -> 0x0000 without macro, 0x0001 with FINAL_SUM_ROUND_EN; lanes {0xFFFF,0,0,0} -> 0xFFFF without, 0x0000 with.
- Stream 8 back-to-back samples (lane0 = 2n, others 0 -> expected n), drop iReady for 4 cycles mid-stream -> oReady low exactly while oValid && !iReady, output sequence 0..7 in order, no loss or repeat.
- Assert iRst for one cycle with 2 samples in flight -> oValid = 0, oFirOut = 0, oSat = 0 next cycle; no stale sample emerges afterward.
- NUM_MAC=8, IN_W=12, OUT_W=12, SHIFT=3, lanes all 0x7FF -> latency 4, oFirOut = 0x7FF, oSat = 0; all 0x800 -> 0x800.

Source files
------------

// File: rtl/final_sum_tree.sv
// final_sum_tree
//
// Pipelined saturating adder tree. It sums NUM_MAC signed MAC lane results
// into one FIR output sample. The full-width sum is arithmetically shifted
// right by SHIFT and then clamped to OUT_W bits. A sticky flag records that a
// clamp happened.
//
// Pipeline: LOG2N registered adder stages followed by one registered output
// stage. Latency is LOG2N+1 cycles when there are no stalls.
//
// Handshake (valid/ready): a transfer happens on any cycle where valid and
// ready are both high.
//   - On the input side, iValid/oReady qualify iMac.
//   - On the output side, oValid/iReady qualify oFirOut.
//   - If the output holds a sample that is not taken (oValid && !iReady), the
//     whole pipeline freezes and oReady drops.
//   - oReady depends only on oValid and iReady.
//
// Ports:
//   iClk, iRst   clock, asynchronous active-high reset
//   iValid       input sample valid
//   oReady       block can accept a sample this cycle
//   iMac         lane k at [k*IN_W +: IN_W], signed
//   oValid       oFirOut holds a valid sample
//   iReady       downstream accepts oFirOut this cycle
//   oFirOut      saturated, shifted sum; holds its last value while oValid=0
//   oSat         sticky: a clamped sample was produced
//   iSatClr      synchronous clear of oSat (a simultaneous set wins)
//
// Optional build macro FINAL_SUM_ROUND_EN: adds 2^(SHIFT-1) before the shift
// (round half up). Without the macro the shift truncates toward minus
// infinity.
module final_sum_tree #(
   parameter int NUM_MAC = 4,
   parameter int IN_W    = 16,
   parameter int OUT_W   = 16,
   parameter int SHIFT   = 1
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic                    iValid,
   output logic                    oReady,
   input  logic [NUM_MAC*IN_W-1:0] iMac,
   output logic                    oValid,
   input  logic                    iReady,
   output logic [OUT_W-1:0]        oFirOut,
   output logic                    oSat,
   input  logic                    iSatClr
);

   localparam int LOG2N = $clog2(NUM_MAC);
   localparam int SW    = IN_W + LOG2N;

   // Every tree level is packed into one flat vector. Level l has
   // NUM_MAC>>l nodes, each IN_W+l bits wide. Level 0 is the raw lanes.
   // This function returns the bit offset where level l starts.
   function automatic int lvl_off(input int l);
      int o;
      o = 0;
      for (int j = 0; j < l; j++) begin
         o = o + (NUM_MAC >> j) * (IN_W + j);
      end
      return o;
   endfunction

   localparam int IN_BITS   = NUM_MAC * IN_W;
   localparam int ALL_BITS  = lvl_off(LOG2N + 1);
   localparam int TREE_BITS = ALL_BITS - IN_BITS;
   localparam int TOP_OFF   = lvl_off(LOG2N);

   localparam logic signed [SW:0] SAT_MAX = (SW+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [SW:0] SAT_MIN = ~SAT_MAX;

   logic [TREE_BITS-1:0] tree_sum;
   logic [TREE_BITS-1:0] tree_d, tree_q;
   logic [ALL_BITS-1:0]  lvl;
   logic [LOG2N-1:0]     vld_d, vld_q;
   logic                 out_vld_d, out_vld_q;
   logic [OUT_W-1:0]     fir_d, fir_q;
   logic                 sat_d, sat_q;

   logic                 stall;
   logic                 load;
   logic                 clamp_hi, clamp_lo;
   logic signed [SW:0]   sum_ext, rnd_sum, shifted;

   assign stall   = out_vld_q && !iReady;
   assign oReady  = !stall;
   assign oValid  = out_vld_q;
   assign oFirOut = fir_q;
   assign oSat    = sat_q;

   // Level 0 is the live input. Levels 1..LOG2N are the stage registers.
   assign lvl = {tree_q, iMac};

   // Each node sign-extends both operands by one bit before adding, so no
   // stage can overflow.
   for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
      localparam int WI = IN_W + s - 1;
      for (genvar k = 0; k < (NUM_MAC >> s); k++) begin : g_node
         logic [WI-1:0] a, b;
         assign a = lvl[lvl_off(s-1) + (2*k)*WI +: WI];
         assign b = lvl[lvl_off(s-1) + (2*k+1)*WI +: WI];
         assign tree_sum[lvl_off(s) - IN_BITS + k*(WI+1) +: WI+1] =
            {a[WI-1], a} + {b[WI-1], b};
      end
   end

   // Tree stages and their valids advance together. All of them hold while
   // stalled. Bubbles advance as well; their data is simply not used.
   always_comb begin
      tree_d = tree_q;
      vld_d  = vld_q;
      if (!stall) begin
         tree_d   = tree_sum;
         vld_d    = vld_q << 1;
         vld_d[0] = iValid;
      end
   end

   // The output stage works one bit wider than the tree result. The rounding
   // add therefore cannot wrap, and the clamp compares happen before any
   // truncation.
`ifdef FINAL_SUM_ROUND_EN
   localparam int             RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [SW:0]    RND_ADD = (SHIFT > 0) ? ((SW+1)'(1) << RND_SH) : '0;
`endif

   always_comb begin
      sum_ext = {lvl[TOP_OFF + SW - 1], lvl[TOP_OFF +: SW]};
`ifdef FINAL_SUM_ROUND_EN
      rnd_sum = sum_ext + RND_ADD;
`else
      rnd_sum = sum_ext;
`endif
      shifted  = rnd_sum >>> SHIFT;
      clamp_hi = shifted > SAT_MAX;
      clamp_lo = shifted < SAT_MIN;
   end

   // The output register only loads real samples. It keeps its last value
   // across bubbles and stalls.
   always_comb begin
      out_vld_d = out_vld_q;
      fir_d     = fir_q;
      sat_d     = sat_q;
      load      = !stall && vld_q[LOG2N-1];
      if (!stall) begin
         out_vld_d = vld_q[LOG2N-1];
      end
      if (load) begin
         if (clamp_hi) begin
            fir_d = SAT_MAX[OUT_W-1:0];
         end else if (clamp_lo) begin
            fir_d = SAT_MIN[OUT_W-1:0];
         end else begin
            fir_d = shifted[OUT_W-1:0];
         end
      end
      if (iSatClr) begin
         sat_d = 1'b0;
      end
      if (load && (clamp_hi || clamp_lo)) begin
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         tree_q    <= '0;
         vld_q     <= '0;
         out_vld_q <= 1'b0;
         fir_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         tree_q    <= tree_d;
         vld_q     <= vld_d;
         out_vld_q <= out_vld_d;
         fir_q     <= fir_d;
         sat_q     <= sat_d;
      end
   end

endmodule

// File: tb/tb_final_sum_tree.sv
// Testbench for final_sum_tree.
// Main instance: default parameters (4 lanes, 16 bit, SHIFT 1).
// Second instance: 8 lanes, 12 bit, SHIFT 3.
module tb_final_sum_tree;

   // ---------------- clock / reset / signals ----------------
   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iValid = 1'b0;
   logic        oReady;
   logic [63:0] iMac = '0;
   logic        oValid;
   logic        iReady = 1'b1;
   logic [15:0] oFirOut;
   logic        oSat;
   logic        iSatClr = 1'b0;

   logic        v8 = 1'b0;
   logic        r8;
   logic [95:0] mac8 = '0;
   logic        ov8;
   logic        rdy8 = 1'b1;
   logic [11:0] out8;
   logic        sat8;
   logic        clr8 = 1'b0;

   always #5 iClk = ~iClk;

   final_sum_tree u_dut (
      .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iMac(iMac),
      .oValid(oValid), .iReady(iReady), .oFirOut(oFirOut), .oSat(oSat),
      .iSatClr(iSatClr)
   );

   final_sum_tree #(.NUM_MAC(8), .IN_W(12), .OUT_W(12), .SHIFT(3)) u_dut8 (
      .iClk(iClk), .iRst(iRst), .iValid(v8), .oReady(r8), .iMac(mac8),
      .oValid(ov8), .iReady(rdy8), .oFirOut(out8), .oSat(sat8),
      .iSatClr(clr8)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          send_cyc = 0;
   int          pop_cyc = 0;
   int          stall_lo = 1000000000;
   int          stall_hi = 1000000000;
   int          ready_low_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_out = '0;

   always @(posedge iClk) cyc <= cyc + 1;

   // iReady pattern: low inside [stall_lo, stall_hi), changes at posedge+1.
   always @(posedge iClk) begin
      #1;
      iReady = !(cyc >= stall_lo && cyc < stall_hi);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic signed [18:0] model_t(input logic [63:0] mac);
      logic signed [18:0] s;
      logic signed [15:0] l;
      s = '0;
      for (int k = 0; k < 4; k++) begin
         l = mac[k*16 +: 16];
         s = s + l;
      end
`ifdef FINAL_SUM_ROUND_EN
      s = s + 19'sd1;
`endif
      return s >>> 1;
   endfunction

   function automatic logic [15:0] model(input logic [63:0] mac);
      logic signed [18:0] t;
      t = model_t(mac);
      if (t > 19'sd32767) return 16'h7fff;
      if (t < -19'sd32768) return 16'h8000;
      return t[15:0];
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge iClk) begin
      if (iRst) begin
         last_out = '0;
      end else begin
         chk("ready_rule", {31'b0, oReady}, {31'b0, !(oValid && !iReady)});
         if (!oReady) ready_low_cnt++;
         if (oValid && iReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h expected none (t=%0t)", oFirOut, $time);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               chk("out", {16'b0, oFirOut}, {16'b0, e});
               last_out = e;
               pop_cyc  = cyc;
            end
         end else if (!oValid) begin
            chk("hold", {16'b0, oFirOut}, {16'b0, last_out});
         end
      end
   end

   // ---------------- driver tasks (entered at posedge+2) ----------------
   task automatic send(input logic [63:0] mac, input logic [15:0] e);
      int n;
      n = 0;
      iMac   = mac;
      iValid = 1'b1;
      while (!oReady && n < 50) begin
         @(posedge iClk); #2;
         n++;
      end
      chk("accept_wait", {31'b0, oReady}, 32'd1);
      exp_q.push_back(e);
      send_cyc = cyc;
      @(posedge iClk); #2;
      iValid = 1'b0;
   endtask

   task automatic tick();
      @(posedge iClk); #2;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   task automatic sat_clear();
      iSatClr = 1'b1;
      tick();
      iSatClr = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [63:0] mac;
      logic [15:0] exp;
      logic        sat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      // Lane 0 is the least significant 16 bits.
      vecs[0]  = '{{4{16'h1000}}, 16'h2000, 1'b0};
      vecs[1]  = '{{4{16'h7fff}}, 16'h7fff, 1'b1};
      vecs[2]  = '{{4{16'h8000}}, 16'h8000, 1'b1};
`ifdef FINAL_SUM_ROUND_EN
      vecs[3]  = '{64'h0000_0000_0000_0001, 16'h0001, 1'b0};
      vecs[4]  = '{64'h0000_0000_0000_ffff, 16'h0000, 1'b0};
      vecs[11] = '{64'h0000_ffff_8000_8000, 16'h8000, 1'b0};
`else
      vecs[3]  = '{64'h0000_0000_0000_0001, 16'h0000, 1'b0};
      vecs[4]  = '{64'h0000_0000_0000_ffff, 16'hffff, 1'b0};
      vecs[11] = '{64'h0000_ffff_8000_8000, 16'h8000, 1'b1};
`endif
      vecs[5]  = '{64'h0040_0300_ff00_0100, 16'h01a0, 1'b0};
      vecs[6]  = '{64'h8000_8000_7fff_7fff, 16'hffff, 1'b0};
      vecs[7]  = '{64'h4000_4000_0000_0000, 16'h4000, 1'b0};
      vecs[8]  = '{64'h0000_0000_7fff_7fff, 16'h7fff, 1'b0};
      vecs[9]  = '{64'h0002_0000_7fff_7fff, 16'h7fff, 1'b1};
      vecs[10] = '{64'h0000_0000_8000_8000, 16'h8000, 1'b0};

      // reset state
      repeat (2) @(posedge iClk);
      #2 iRst = 1'b0;
      @(negedge iClk);
      chk("rst_valid", {31'b0, oValid}, 32'd0);
      chk("rst_out", {16'b0, oFirOut}, 32'd0);
      chk("rst_sat", {31'b0, oSat}, 32'd0);
      chk("rst_ready", {31'b0, oReady}, 32'd1);
      tick();

      // table: one sample at a time, check value, latency and sat flag
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].mac, vecs[i].exp);
         wait_drain();
         if (i == 0) chk("latency", pop_cyc - send_cyc, 32'd3);
         chk("sat_flag", {31'b0, oSat}, {31'b0, vecs[i].sat});
         sat_clear();
         chk("sat_clr", {31'b0, oSat}, 32'd0);
      end

      // clear on the same cycle the clamped sample loads: set wins
      send({4{16'h8000}}, 16'h8000);
      tick();
      iSatClr = 1'b1;
      tick();
      iSatClr = 1'b0;
      chk("sat_set_wins", {31'b0, oSat}, 32'd1);
      wait_drain();
      sat_clear();
      chk("sat_clr_alone", {31'b0, oSat}, 32'd0);

      // back-to-back stream with a 4-cycle iReady drop
      ready_low_cnt = 0;
      stall_lo = cyc + 4;
      stall_hi = stall_lo + 4;
      for (int n = 0; n < 8; n++) begin
         logic [15:0] l0;
         l0 = 16'(2 * n);
         send({48'b0, l0}, 16'(n));
      end
      wait_drain();
      chk("stall_ready_low", ready_low_cnt, 32'd4);
      stall_lo = 1000000000;
      stall_hi = 1000000000;

      // random back-to-back samples checked against the model
      for (int n = 0; n < 10; n++) begin
         logic [63:0] m;
         m = {$urandom, $urandom};
         send(m, model(m));
      end
      wait_drain();
      sat_clear();

      // reset with two samples in flight
      send({4{16'h7fff}}, 16'h7fff);
      wait_drain();
      chk("sat_before_rst", {31'b0, oSat}, 32'd1);
      send({4{16'h1000}}, 16'h2000);
      send({4{16'h0800}}, 16'h1000);
      iRst = 1'b1;
      exp_q.delete();
      tick();
      iRst = 1'b0;
      @(negedge iClk);
      chk("mid_rst_valid", {31'b0, oValid}, 32'd0);
      chk("mid_rst_out", {16'b0, oFirOut}, 32'd0);
      chk("mid_rst_sat", {31'b0, oSat}, 32'd0);
      tick();
      repeat (8) tick();
      send({4{16'h0400}}, 16'h0800);
      wait_drain();

      // 8-lane, 12-bit, SHIFT 3 instance
      for (int pass = 0; pass < 2; pass++) begin
         int s8;
         int n;
         logic [11:0] e8;
         e8   = (pass == 0) ? 12'h7ff : 12'h800;
         mac8 = {8{e8}};
         v8   = 1'b1;
         s8   = cyc;
         tick();
         v8 = 1'b0;
         n  = 0;
         @(negedge iClk);
         while (!ov8 && n < 20) begin
            @(negedge iClk);
            n++;
         end
         chk("n8_valid", {31'b0, ov8}, 32'd1);
         chk("n8_latency", cyc - s8, 32'd4);
         chk("n8_out", {20'b0, out8}, {20'b0, e8});
         chk("n8_sat", {31'b0, sat8}, 32'd0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
